video_frame_switch: RTL and testbench
=====================================

Name: video_frame_switch

Overview:
- Frame-aligned 2:1 scheduler for AXI4-Stream video.
- Tags: tuser = start of frame (SOF), tlast = end of line (EOL).
- Sits between two video sources (pattern generator, capture path) and the single hdmi_tx input. It shares the one TMDS output between them.
- Source changes happen only at frame boundaries, so hdmi_tx never sees a torn frame. The unselected source is flushed so its free-running timing is never stalled.

Parameters:
- DATA_WIDTH, 32, pixel bus width in bits.
- X_ACTIVE, 1920, active pixels per line.
- Y_ACTIVE, 1080, active lines per frame.

Ports:
- clk_i  input  1  pixel clock (px_clk domain).
- rst_i  input  1  asynchronous, active-high reset.
- sel_i  input  1  requested source (0 = s0, 1 = s1); sampled only at frame boundaries.
- s0_tdata_i  input  DATA_WIDTH  source 0 pixel.
- s0_tvalid_i  input  1  source 0 valid.
- s0_tuser_i  input  1  source 0 SOF.
- s0_tlast_i  input  1  source 0 EOL.
- s0_tready_o  output  1  source 0 ready.
- s1_tdata_i / s1_tvalid_i / s1_tuser_i / s1_tlast_i / s1_tready_o: same as s0, for source 1.
- m_tdata_o  output  DATA_WIDTH  pixel to hdmi_tx.
- m_tvalid_o  output  1  output valid.
- m_tuser_o  output  1  output SOF.
- m_tlast_o  output  1  output EOL.
- m_tready_i  input  1  downstream ready.
- active_o  output  1  source currently routed.
- locked_o  output  1  high while in STREAM.
- err_o  output  1  sticky framing-error flag.

Behaviour:
- Reset values (async on rst_i high): state=SYNC, active_o=0, locked_o=0, err_o=0, px_cnt=0, line_cnt=0.
- Reset mid-frame discards the frame in progress; the next SOF is required before any output beat.
- Datapath: m_t*_o is combinationally muxed from the active source. Zero latency, no buffering. Active source tready = m_tready_i in STREAM.
- Unselected source: tready forced 1; its beats are consumed and dropped.
- Counters: px_cnt is clog2(X_ACTIVE) bits and line_cnt is clog2(Y_ACTIVE) bits. Both advance only on an output handshake (m_tvalid_o & m_tready_i) in STREAM.
  - px_cnt increments per beat and clears on tlast.
  - line_cnt increments on tlast.
- State SYNC:
  - Active source tready=1 and m_tvalid_o=0, so non-SOF beats are dropped.
  - When the active source shows tvalid & tuser: go to STREAM in the same cycle. That beat is forwarded (not dropped) with tready = m_tready_i.
  - Counters are zero.
- State STREAM:
  - Frame end = handshake with tlast & line_cnt==Y_ACTIVE-1. On frame end, px_cnt and line_cnt are cleared.
  - On frame end with sel_i != active_o: active_o <= sel_i, go to SYNC (wait for the new source's SOF).
  - On frame end with sel_i == active_o: stay in STREAM; the next beat must carry tuser.
- Framing errors (err_o set, sticky until reset) — any of these:
  - tlast with px_cnt != X_ACTIVE-1;
  - tuser with (px_cnt,line_cnt) != (0,0);
  - missing tuser on the first beat of a frame.
- Framing-error recovery:
  - tuser error: the beat is treated as a new SOF; counters restart at 0/0 counting this beat; state unchanged.
  - tlast error: px_cnt cleared and line_cnt incremented as normal.
- sel_i toggling during a frame has no effect until frame end. Only the value present at the frame-end handshake cycle is used.
- Simultaneous frame end and sel change: the switch takes effect on that frame end.
- Backpressure: while m_tready_i=0 in STREAM, the active source is stalled and its data/tuser/tlast are held on m_t*_o.

Test Plan:
- sel_i=0 constant, s0 frames of 8x4 (X_ACTIVE=8, Y_ACTIVE=4) -> 32 beats per frame out; tuser only on beat 0, tlast on beats 7/15/23/31; err_o=0; s1_tready_o=1 throughout.
- sel_i 0->1 asserted at beat 10 of a frame -> s0 frame completes all 32 beats, then locked_o=0. Beats of s1 before its SOF are dropped. First output beat after the switch has m_tuser_o=1, active_o=1.
- Reset at beat 12 of a frame -> all outputs 0 asynchronously. After release, no output until the next s0 tuser, which is forwarded as beat 0.
- Random m_tready_i (50%) over 3 frames -> output sequence identical to the no-backpressure run; signals stable while stalled.
- s0 asserts tuser at beat 5 of line 2 -> err_o=1 and stays 1. Output continues with a new frame starting at that beat; the following frame is counted correctly.
- s0 tlast at px_cnt=5 -> err_o=1; next line counting resumes from px_cnt=0.

Source files
------------

// File: rtl/video_frame_switch_if.sv
// AXI4-Stream video link: tuser marks start of frame, tlast marks end of line.
interface video_frame_switch_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tuser;
  logic                  tlast;
  logic                  tready;

  modport master (output tdata, tvalid, tuser, tlast, input  tready);
  modport slave  (input  tdata, tvalid, tuser, tlast, output tready);
endinterface

// File: rtl/video_frame_switch.sv
// Frame-aligned 2:1 video stream switch: the routed source only changes at a
// frame boundary, and the source not routed is drained so it never stalls.
module video_frame_switch #(
  parameter int DATA_WIDTH = 32,
  parameter int X_ACTIVE   = 1920,
  parameter int Y_ACTIVE   = 1080
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 sel_i,
  video_frame_switch_if.slave  s0,
  video_frame_switch_if.slave  s1,
  video_frame_switch_if.master m,
  output logic                 active_o,
  output logic                 locked_o,
  output logic                 err_o
);
  localparam int PXW = (X_ACTIVE > 1) ? $clog2(X_ACTIVE) : 1;
  localparam int LNW = (Y_ACTIVE > 1) ? $clog2(Y_ACTIVE) : 1;

  typedef enum logic {SYNC, STREAM} state_t;
  typedef struct packed {
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tuser;
    logic                  tlast;
  } beat_t;

  state_t         state_q, state_d;
  logic           active_d, err_d;
  logic [PXW-1:0] px_q, px_d, px_base;
  logic [LNW-1:0] line_q, line_d, line_base;

  beat_t a_beat;
  logic  a_tvalid, a_tready;
  logic  sof, fwd, hs, frame_end, tlast_err, tuser_err, miss_err;

  // Route the active source; everything else about it is decided by fwd.
  always_comb begin
    a_beat   = active_o ? {s1.tdata, s1.tuser, s1.tlast} : {s0.tdata, s0.tuser, s0.tlast};
    a_tvalid = active_o ? s1.tvalid : s0.tvalid;
  end

  // In SYNC only an SOF beat is passed on; all other beats are swallowed.
  assign sof      = a_tvalid & a_beat.tuser;
  assign fwd      = ~rst_i & ((state_q == STREAM) | sof);
  assign a_tready = fwd ? m.tready : 1'b1;

  assign m.tvalid  = fwd & a_tvalid;
  assign m.tdata   = fwd ? a_beat.tdata : '0;
  assign m.tuser   = fwd & a_beat.tuser;
  assign m.tlast   = fwd & a_beat.tlast;
  assign s0.tready = active_o ? 1'b1 : a_tready;
  assign s1.tready = active_o ? a_tready : 1'b1;

  assign hs       = m.tvalid & m.tready;
  assign locked_o = (state_q == STREAM);

  // A tuser beat restarts the raster at 0/0, whether expected or not.
  assign px_base   = a_beat.tuser ? '0 : px_q;
  assign line_base = a_beat.tuser ? '0 : line_q;

  assign frame_end = hs & a_beat.tlast & (line_base == LNW'(Y_ACTIVE - 1));
  assign tlast_err = hs & a_beat.tlast & (px_base != PXW'(X_ACTIVE - 1));
  assign tuser_err = hs & a_beat.tuser & ((px_q != '0) | (line_q != '0));
  assign miss_err  = hs & ~a_beat.tuser & (px_q == '0) & (line_q == '0);

  always_comb begin
    state_d  = state_q;
    active_d = active_o;
    px_d     = px_q;
    line_d   = line_q;
    err_d    = err_o | tlast_err | tuser_err | miss_err;

    if (hs) begin
      if (a_beat.tlast) begin
        px_d   = '0;
        line_d = frame_end ? '0 : line_base + LNW'(1);
      end else begin
        px_d   = px_base + PXW'(1);
        line_d = line_base;
      end
    end

    case (state_q)
      SYNC:   if (sof) state_d = STREAM;
      STREAM: if (frame_end && (sel_i != active_o)) begin
        state_d  = SYNC;
        active_d = sel_i;
      end
      default: state_d = SYNC;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= SYNC;
      active_o <= 1'b0;
      err_o    <= 1'b0;
      px_q     <= '0;
      line_q   <= '0;
    end else begin
      state_q  <= state_d;
      active_o <= active_d;
      err_o    <= err_d;
      px_q     <= px_d;
      line_q   <= line_d;
    end
  end
endmodule

// File: tb/tb_video_frame_switch.sv
// Directed bench for video_frame_switch with two free-running 8x4 sources.
module tb_video_frame_switch;
  localparam int DW = 32;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          u;
    logic          l;
  } obeat_t;

  logic clk = 1'b0;
  logic rst, sel;
  logic active, locked, err;

  video_frame_switch_if #(.DATA_WIDTH(DW)) s0_if ();
  video_frame_switch_if #(.DATA_WIDTH(DW)) s1_if ();
  video_frame_switch_if #(.DATA_WIDTH(DW)) m_if ();

  video_frame_switch #(.DATA_WIDTH(DW), .X_ACTIVE(8), .Y_ACTIVE(4)) dut (
    .clk_i(clk), .rst_i(rst), .sel_i(sel),
    .s0(s0_if), .s1(s1_if), .m(m_if),
    .active_o(active), .locked_o(locked), .err_o(err)
  );

  always #5 clk = ~clk;

  // Sources: beat index idx within a 32-beat frame; data = {src, frame, idx}.
  int idx0 = 0, idx1 = 0, fr0 = 0, fr1 = 0;
  int tuser_at0 = -1, tlast_at0 = -1;

  always_comb begin
    s0_if.tvalid = 1'b1;
    s0_if.tdata  = {8'd0, 8'(fr0), 16'(idx0)};
    s0_if.tuser  = (idx0 == 0) || (idx0 == tuser_at0);
    s0_if.tlast  = (idx0 % 8 == 7) || (idx0 == tlast_at0);
    s1_if.tvalid = 1'b1;
    s1_if.tdata  = {8'd1, 8'(fr1), 16'(idx1)};
    s1_if.tuser  = (idx1 == 0);
    s1_if.tlast  = (idx1 % 8 == 7);
  end

  always @(posedge clk) begin
    if (s0_if.tvalid && s0_if.tready) begin
      if (idx0 == tuser_at0)      idx0 <= 1;
      else if (idx0 == tlast_at0) idx0 <= (idx0 / 8 + 1) * 8;
      else if (idx0 == 31)        begin idx0 <= 0; fr0 <= fr0 + 1; end
      else                        idx0 <= idx0 + 1;
    end
    if (s1_if.tvalid && s1_if.tready) begin
      if (idx1 == 31) begin idx1 <= 0; fr1 <= fr1 + 1; end
      else            idx1 <= idx1 + 1;
    end
  end

  obeat_t out_log[$];
  int s0_low = 0, s1_low = 0;

  always @(negedge clk) begin
    if (m_if.tvalid && m_if.tready) out_log.push_back({m_if.tdata, m_if.tuser, m_if.tlast});
    if (!s0_if.tready) s0_low <= s0_low + 1;
    if (!s1_if.tready) s1_low <= s1_low + 1;
  end

  int n_cmp = 0, n_bad = 0;

  task automatic wait_locked(input logic v, input int lim, output bit ok);
    ok = 0;
    for (int i = 0; i < lim; i++) begin
      if (locked === v) begin ok = 1; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_size(input int n, input int lim, output bit ok);
    ok = 0;
    for (int i = 0; i < lim; i++) begin
      if (out_log.size() >= n) begin ok = 1; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1; sel = 1'b0; tuser_at0 = -1; tlast_at0 = -1; m_if.tready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; sel = 1'b0; m_if.tready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (m_if.tvalid !== 1'b0) begin n_bad++; $display("FAIL reset_tvalid got %b want 0", m_if.tvalid); end
    n_cmp++; if ({active, locked, err} !== 3'b000) begin n_bad++; $display("FAIL reset_flags got %b want 000", {active, locked, err}); end
    n_cmp++; if (s1_if.tready !== 1'b1) begin n_bad++; $display("FAIL reset_s1_ready got %b want 1", s1_if.tready); end
    rst = 1'b0;
  endtask

  task automatic test_frame();
    int base, kf, bad, s1l;
    bit ok;
    base = out_log.size(); s1l = s1_low;
    wait_size(base + 70, 300, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL frame_timeout got %0d beats want %0d", out_log.size() - base, 70); end
    kf = -1;
    for (int j = base; j < out_log.size(); j++) if (out_log[j].u) begin kf = j; break; end
    bad = 0;
    if (kf < 0 || kf + 32 > out_log.size()) bad = 99;
    else for (int i = 0; i < 32; i++) begin
      if (out_log[kf+i].d[31:24] !== 8'd0 || out_log[kf+i].d[15:0] !== 16'(i) ||
          out_log[kf+i].u !== (i == 0) || out_log[kf+i].l !== (i % 8 == 7)) bad++;
    end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL frame_beats got %0d bad beats want 0", bad); end
    n_cmp++; if ({locked, err} !== 2'b10) begin n_bad++; $display("FAIL frame_flags got %b want 10", {locked, err}); end
    n_cmp++; if (s1_low != s1l) begin n_bad++; $display("FAIL frame_s1_ready got %0d low cycles want 0", s1_low - s1l); end
  endtask

  task automatic test_switch();
    int base, b2, n;
    bit ok;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      if (idx0 == 10 && locked === 1'b1 && active === 1'b0) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL switch_find_beat10 got timeout want idx 10"); end
    sel = 1'b1; base = out_log.size();
    wait_locked(1'b0, 100, ok);
    n = out_log.size() - base;
    n_cmp++; if (!ok || n != 22) begin n_bad++; $display("FAIL switch_s0_tail got %0d beats want 22", n); end
    n_cmp++; if (n < 1 || out_log[out_log.size()-1] !== {8'd0, 8'(out_log[out_log.size()-1].d[23:16]), 16'd31, 1'b0, 1'b1})
      begin n_bad++; $display("FAIL switch_last_s0 got %h want idx 31 tlast", out_log.size() > 0 ? out_log[out_log.size()-1] : '0); end
    n_cmp++; if (active !== 1'b1) begin n_bad++; $display("FAIL switch_active got %b want 1", active); end
    b2 = out_log.size();
    wait_size(b2 + 1, 100, ok);
    n_cmp++; if (!ok || out_log[b2].d[31:24] !== 8'd1 || out_log[b2].d[15:0] !== 16'd0 || out_log[b2].u !== 1'b1)
      begin n_bad++; $display("FAIL switch_first_s1 got %h want s1 idx 0 tuser", ok ? out_log[b2] : '0); end
    wait_locked(1'b1, 10, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL switch_relock got %b want 1", locked); end
  endtask

  task automatic test_back_to_back_stall();
    int base, bad, stall_bad, s0l, pi, ci;
    bit prev_stall, nrdy, ok;
    logic [DW-1:0] pd;
    logic pu, pl;
    base = out_log.size(); s0l = s0_low;
    prev_stall = 0; stall_bad = 0; pd = '0; pu = 0; pl = 0; ok = 0;
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #1;
      if (prev_stall && (m_if.tvalid !== 1'b1 || m_if.tdata !== pd || m_if.tuser !== pu || m_if.tlast !== pl))
        stall_bad++;
      if (out_log.size() >= base + 97) begin ok = 1; break; end
      nrdy = 1'($urandom_range(0, 1));
      m_if.tready = nrdy;
      prev_stall = m_if.tvalid && !nrdy;
      pd = m_if.tdata; pu = m_if.tuser; pl = m_if.tlast;
    end
    m_if.tready = 1'b1;
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL bp_timeout got %0d beats want 97", out_log.size() - base); end
    bad = 0;
    if (ok) for (int j = base + 1; j < base + 97; j++) begin
      pi = int'(out_log[j-1].d[15:0]); ci = (pi + 1) % 32;
      if (out_log[j].d[31:24] !== 8'd1 || int'(out_log[j].d[15:0]) != ci ||
          out_log[j].u !== (ci == 0) || out_log[j].l !== (ci % 8 == 7)) bad++;
    end
    n_cmp++; if (bad != 0) begin n_bad++; $display("FAIL bp_sequence got %0d bad beats want 0", bad); end
    n_cmp++; if (stall_bad != 0) begin n_bad++; $display("FAIL bp_hold got %0d unstable stalls want 0", stall_bad); end
    n_cmp++; if (s0_low != s0l) begin n_bad++; $display("FAIL bp_s0_ready got %0d low cycles want 0", s0_low - s0l); end
  endtask

  task automatic test_reset_midframe();
    int base;
    bit ok;
    sel = 1'b0; ok = 0;
    for (int i = 0; i < 200; i++) begin
      if (active === 1'b0 && locked === 1'b1 && idx0 == 12) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL rstmid_find got timeout want s0 beat 12"); end
    rst = 1'b1;
    #1;
    n_cmp++; if (m_if.tvalid !== 1'b0 || m_if.tdata !== '0 || m_if.tuser !== 1'b0 || m_if.tlast !== 1'b0)
      begin n_bad++; $display("FAIL rstmid_outputs got v%b d%h want all 0", m_if.tvalid, m_if.tdata); end
    n_cmp++; if ({active, locked, err} !== 3'b000) begin n_bad++; $display("FAIL rstmid_flags got %b want 000", {active, locked, err}); end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    base = out_log.size();
    wait_size(base + 1, 100, ok);
    n_cmp++; if (!ok || out_log[base].d[31:24] !== 8'd0 || out_log[base].d[15:0] !== 16'd0 || out_log[base].u !== 1'b1)
      begin n_bad++; $display("FAIL rstmid_first got %h want s0 idx 0 tuser", ok ? out_log[base] : '0); end
  endtask

  task automatic test_tuser_err();
    int n0, n;
    bit ok;
    pulse_reset();
    wait_locked(1'b1, 100, ok);
    n_cmp++; if (!ok || err !== 1'b0) begin n_bad++; $display("FAIL tuser_pre got locked %b err %b want 1 0", locked, err); end
    tuser_at0 = 21; ok = 0;
    for (int i = 0; i < 100; i++) begin
      if (err === 1'b1) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL tuser_err_set got %b want 1", err); end
    n0 = out_log.size();
    n_cmp++; if (out_log[n0-1].d[15:0] !== 16'd21 || out_log[n0-1].u !== 1'b1)
      begin n_bad++; $display("FAIL tuser_err_beat got %h want idx 21 tuser", out_log[n0-1]); end
    tuser_at0 = -1; sel = 1'b1;
    wait_locked(1'b0, 100, ok);
    n = out_log.size() - n0;
    n_cmp++; if (!ok || n != 31) begin n_bad++; $display("FAIL tuser_new_frame got %0d beats want 31", n); end
    n_cmp++; if ({err, active} !== 2'b11) begin n_bad++; $display("FAIL tuser_sticky got %b want 11", {err, active}); end
  endtask

  task automatic test_tlast_err();
    int sof_i, n;
    bit ok;
    pulse_reset();
    wait_locked(1'b1, 100, ok);
    sof_i = out_log.size() - 1;
    n_cmp++; if (!ok || err !== 1'b0 || out_log[sof_i].u !== 1'b1)
      begin n_bad++; $display("FAIL tlast_pre got err %b tuser %b want 0 1", err, out_log[sof_i].u); end
    tlast_at0 = 5; sel = 1'b1;
    wait_locked(1'b0, 100, ok);
    n = out_log.size() - sof_i;
    n_cmp++; if (!ok || n != 30) begin n_bad++; $display("FAIL tlast_frame_len got %0d beats want 30", n); end
    n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL tlast_err_set got %b want 1", err); end
    n_cmp++; if (out_log[sof_i+5].l !== 1'b1 || out_log[sof_i+6].d[15:0] !== 16'd8)
      begin n_bad++; $display("FAIL tlast_line_resume got %h want idx 8", out_log[sof_i+6]); end
    tlast_at0 = -1;
  endtask

  initial begin
    test_reset();
    test_frame();
    test_switch();
    test_back_to_back_stall();
    test_reset_midframe();
    test_tuser_err();
    test_tlast_err();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
